// File: rtl/seq_det_pkg.sv
// Shared constants for the 1101 sequencing controller and its detector core.
// No logic; detector states are one-hot, controller states binary.
// Pattern bits are listed MSB-first, in the order they arrive on the serial line.
package seq_det_pkg;

    typedef logic [4:0] det_state_t;

    localparam det_state_t DET_S0 = 5'b00001;
    localparam det_state_t DET_S1 = 5'b00010;
    localparam det_state_t DET_S2 = 5'b00100;
    localparam det_state_t DET_S3 = 5'b01000;
    localparam det_state_t DET_S4 = 5'b10000;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_DONE = 2'd2
    } ctrl_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/det_1101_core.sv
// Moore 1101 detector; z is registered state S4, hit is next-state==S4 qualified by en.
// Latency: one bit per en cycle, no backpressure. SEQ_DET_OVERLAP_EN lets a match's trailing 1 seed the next.
module det_1101_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z,
    output logic hit
);

    det_state_t state;
    det_state_t nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DET_S0;
        end else if (clr) begin
            state <= DET_S0;
        end else if (en) begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = DET_S0;
        case (state)
            DET_S0: nxt = (x == PATTERN[3]) ? DET_S1 : DET_S0;
            DET_S1: nxt = (x == PATTERN[2]) ? DET_S2 : DET_S0;
            // a repeated 1 still leaves "11" as a valid prefix
            DET_S2: nxt = (x == PATTERN[1]) ? DET_S3 : DET_S2;
            DET_S3: nxt = (x == PATTERN[0]) ? DET_S4 : DET_S0;
`ifdef SEQ_DET_OVERLAP_EN
            DET_S4: nxt = x ? DET_S2 : DET_S0;
`else
            DET_S4: nxt = x ? DET_S1 : DET_S0;
`endif
            default: nxt = DET_S0;
        endcase
    end

    always_comb begin
        z   = (state == DET_S4);
        hit = en && (nxt == DET_S4);
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serialises a latched word MSB-first into the 1101 detector and records match positions/count.
// Latency: one bit per TICK_DIV cycles (auto) or per step pulse (manual); start ignored unless IDLE.
// No downstream backpressure; done is a one-cycle pulse after the last bit.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data,
    input  logic                       manual,
    input  logic                       step,
    output logic                       busy,
    output logic                       done,
    output logic                       serial_bit,
    output logic                       z,
    output logic [$clog2(WIDTH):0]     match_cnt,
    output logic [WIDTH-1:0]           match_mask
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    ctrl_state_t      state;
    ctrl_state_t      nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [DW-1:0]    div;
    logic             accept;
    logic             bit_evt;
    logic             last_evt;
    logic             hit;
    logic [WIDTH-1:0] hit_bit;

    assign accept     = (state == CTRL_IDLE) && start;
    assign bit_evt    = (state == CTRL_RUN) && (manual ? step : (div == DW'(TICK_DIV - 1)));
    assign last_evt   = bit_evt && (bit_cnt == CW'(WIDTH - 1));
    assign serial_bit = shreg[WIDTH-1];
    // event k lands on mask bit WIDTH-1-k
    assign hit_bit    = {1'b1, {(WIDTH-1){1'b0}}} >> bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CTRL_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            CTRL_IDLE: if (start) nxt = CTRL_RUN;
            CTRL_RUN:  if (last_evt) nxt = CTRL_DONE;
            CTRL_DONE: nxt = CTRL_IDLE;
            default:   nxt = CTRL_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CTRL_RUN);
        done = (state == CTRL_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div        <= '0;
            match_cnt  <= '0;
            match_mask <= '0;
        end else if (accept) begin
            shreg      <= data;
            bit_cnt    <= '0;
            div        <= '0;
            match_cnt  <= '0;
            match_mask <= '0;
        end else if (state == CTRL_RUN) begin
            // manual mode parks the divider so auto mode restarts a full period
            if (manual || bit_evt) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
            if (bit_evt) begin
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (hit) begin
                match_cnt  <= match_cnt + CW'(1);
                match_mask <= match_mask | hit_bit;
            end
        end
    end

    det_1101_core u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (bit_evt),
        .x   (shreg[WIDTH-1]),
        .z   (z),
        .hit (hit)
    );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomised and directed bench for seq_det_ctrl against a window-scan reference of the 1101 rule.
// Two instances: TICK_DIV=1 for bit-level checks and TICK_DIV=4 for divider timing.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, manual, step;
    logic [7:0] data;
    logic       busy, done, serial_bit, z;
    logic [3:0] match_cnt;
    logic [7:0] match_mask;

    logic       start4, manual4, step4;
    logic [7:0] data4;
    logic       busy4, done4, serial_bit4, z4;
    logic [3:0] match_cnt4;
    logic [7:0] match_mask4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.WIDTH(8), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .manual(manual), .step(step),
        .busy(busy), .done(done), .serial_bit(serial_bit), .z(z),
        .match_cnt(match_cnt), .match_mask(match_mask)
    );

    seq_det_ctrl #(.WIDTH(8), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .data(data4), .manual(manual4), .step(step4),
        .busy(busy4), .done(done4), .serial_bit(serial_bit4), .z(z4),
        .match_cnt(match_cnt4), .match_mask(match_mask4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan every 4-bit window in arrival order; without overlap a window may not reuse a matched bit.
    function automatic logic [7:0] ref_mask(input logic [7:0] d);
        logic [7:0] m;
        logic [3:0] win;
        int         last;
        m    = '0;
        last = -4;
        for (int k = 3; k < 8; k++) begin
            win = d[10-k -: 4];
            if (win == 4'b1101 && (OVL || (k - 3 > last))) begin
                m[7-k] = 1'b1;
                last   = k;
            end
        end
        return m;
    endfunction

    task automatic do_run(input logic [7:0] d, input bit man, input int first_gap);
        logic [7:0] m, pm, all1, sd;
        int         gap;
        m    = ref_mask(d);
        all1 = 8'hFF;
        @(negedge clk);
        start  = 1'b1;
        data   = d;
        manual = man;
        step   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
        check_eq("start_busy", busy, 1);
        check_eq("start_done", done, 0);
        check_eq("start_serial", serial_bit, d[7]);
        check_eq("start_cnt", match_cnt, 0);
        check_eq("start_mask", match_mask, 0);
        for (int k = 0; k < 8; k++) begin
            if (man) begin
                gap = (k == 0) ? first_gap : $urandom_range(0, 4);
                repeat (gap) begin
                    start = 1'($urandom);
                    @(negedge clk);
                    sd = d << k;
                    check_eq("hold_busy", busy, 1);
                    check_eq("hold_serial", serial_bit, sd[7]);
                end
                start = 1'b0;
                step  = 1'b1;
                @(negedge clk);
                step = 1'b0;
            end else begin
                step  = 1'($urandom);
                start = 1'($urandom);
                @(negedge clk);
                start = 1'b0;
                step  = 1'b0;
            end
            pm = m & (all1 << (7 - k));
            sd = d << (k + 1);
            check_eq("evt_z", z, m[7-k]);
            check_eq("evt_cnt", match_cnt, $countones(pm));
            check_eq("evt_mask", match_mask, pm);
            check_eq("evt_serial", serial_bit, sd[7]);
            check_eq("evt_busy", busy, (k < 7));
            check_eq("evt_done", done, (k == 7));
        end
        @(negedge clk);
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("hold_cnt", match_cnt, $countones(m));
        check_eq("hold_mask", match_mask, m);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        manual  = 1'b0;
        step    = 1'b0;
        data    = '0;
        start4  = 1'b0;
        manual4 = 1'b0;
        step4   = 1'b0;
        data4   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_serial", serial_bit, 0);
        check_eq("rst_z", z, 0);
        check_eq("rst_cnt", match_cnt, 0);
        check_eq("rst_mask", match_mask, 0);

        do_run(8'b1101_0000, 1'b0, 0);
        check_eq("tp1_mask", match_mask, 8'b0001_0000);
        check_eq("tp1_cnt", match_cnt, 1);
        do_run(8'b1101_1010, 1'b0, 0);
        check_eq("tp2_mask", match_mask, OVL ? 8'b0001_0010 : 8'b0001_0000);
        check_eq("tp2_cnt", match_cnt, OVL ? 2 : 1);
        do_run(8'hFF, 1'b0, 0);
        check_eq("tp3_cnt", match_cnt, 0);
        do_run(8'h00, 1'b0, 0);
        check_eq("tp4_mask", match_mask, 0);
        do_run(8'b0110_1000, 1'b1, 20);
        check_eq("tp5_mask", match_mask, 8'b0000_1000);
        check_eq("tp5_cnt", match_cnt, 1);

        // reset after the third event of an auto run
        @(negedge clk);
        start = 1'b1;
        data  = 8'b1101_0000;
        manual = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_serial", serial_bit, 0);
        check_eq("mid_rst_z", z, 0);
        check_eq("mid_rst_cnt", match_cnt, 0);
        check_eq("mid_rst_mask", match_mask, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
        end
        do_run(8'b1101_0000, 1'b0, 0);
        check_eq("post_rst_cnt", match_cnt, 1);

        // TICK_DIV=4: done exactly 32 edges after start; a start mid-run is ignored
        @(negedge clk);
        start4 = 1'b1;
        data4  = 8'b1101_0000;
        @(negedge clk);
        start4 = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            start4 = (j == 10);
            data4  = (j == 10) ? 8'hFF : 8'b1101_0000;
            @(negedge clk);
            check_eq("div4_busy", busy4, (j < 32));
            check_eq("div4_done", done4, (j == 32));
        end
        start4 = 1'b0;
        check_eq("div4_cnt", match_cnt4, 1);
        check_eq("div4_mask", match_mask4, 8'b0001_0000);

        repeat (40) do_run(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
